robo_n: RTL and testbench
=========================

# robo_n

Parametrised wall-following robot controller for the grid-map labs. Each clock it samples the obstacle sensors and issues at most one action: advance, turn toward the followed wall, or remove debris. It also tracks its own pose, counts moves and removals, and stops on a move budget or when enclosed. It drops into the existing map testbench flow in place of the single-mode controller, and adds a follow-side mode, on-chip pose, boundary walls and halt detection.

## Interface
- GRID, 20: map is GRID×GRID cells, rows and columns numbered 1..GRID.
- POS_W, 5: width of row/col; must satisfy 2^POS_W > GRID.
- FOLLOW_RIGHT, 0: 0 = left-hand follow, turns CCW; 1 = right-hand follow, turns CW.
- START_ROW, 1 / START_COL, 1 / START_DIR, 2'b00: pose loaded at reset.
- MAX_MOVES, 8'd200: advance budget; must be ≥1.
- STUCK_TURNS, 8: consecutive turns without an advance that trigger halt.
- CNT_W, 8: width of move_count and rem_count.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- head  in  1  obstacle in the cell ahead.
- side  in  1  obstacle on the followed side (left if FOLLOW_RIGHT=0, else right).
- under  in  1  debris in the current cell.
- barrier  in  1  obstacle ahead is removable.
- avancar  out  1  advance one cell this cycle.
- girar  out  1  rotate 90° toward the follow side this cycle.
- remover  out  1  remove debris this cycle.
- halt  out  1  sticky stop flag.
- row, col  out  POS_W  current pose, post-action.
- dir  out  2  orientation: N=00, S=01, L=10 (east), O=11 (west).
- move_count, rem_count  out  CNT_W  advances issued; removals issued (saturating).

## Operation
- Action outputs (avancar, girar, remover) are registered and mutually exclusive. All three are 0 in HALT.
- The pose update lands on the same edge as the action.
- Rotation order:
  - CCW: N→O→S→L→N.
  - CW: N→L→S→O→N.
- Advance effect: N row−1, S row+1, L col+1, O col−1.
- Virtual wall: facing outward at row 1/GRID or col 1/GRID forces effective head=1, so the pose never leaves 1..GRID.
- Removal priority applies in SEEK, FOLLOW and STEP only:
  - under=1 → remover.
  - Otherwise head=1 and barrier=1 (real obstacle, not virtual wall) → remover.
  - Removal leaves state and pose unchanged and does not touch turn_run.
- States:
  - SEEK (reset state): head=0 → avancar. head=1 → girar, rot_left=2, go ROTATE (three turns total put the wall on the follow side).
  - FOLLOW:
    - side=0 → girar, go STEP.
    - side=1 and head=0 → avancar.
    - side=1 and head=1 → girar, rot_left=2, go ROTATE.
  - STEP: head=0 → avancar, go FOLLOW. head=1 → girar, rot_left=2, go ROTATE.
  - ROTATE: sensors ignored. girar every cycle, rot_left−1; the cycle with rot_left=1 goes to FOLLOW.
  - HALT: absorbing until reset.
- turn_run counter:
  - +1 on each girar; cleared on avancar.
  - The girar that makes turn_run=STUCK_TURNS sets halt on the same edge, and next state is HALT. This overrides ROTATE.
- move_count +1 on each avancar. The avancar that makes move_count=MAX_MOVES also sets halt.
- rem_count +1 on each remover, saturating at all-ones.

## Timing
- Latency 1: sensors sampled at edge k drive the actions and pose visible after edge k.
- Reset values:
  - avancar=girar=remover=halt=0.
  - row=START_ROW, col=START_COL, dir=START_DIR.
  - move_count=rem_count=0.
  - state SEEK, rot_left=0, turn_run=0.
- Reset mid-ROTATE or in HALT: full reinitialisation on the next edge. Reset has priority over everything.
- The halting action is visible in the same cycle as halt=1. All later cycles show no actions and a frozen pose and counters.

## Structure
- Package robo_pkg:
  - Direction constants N/S/L/O.
  - State encoding SEEK/FOLLOW/STEP/ROTATE/HALT.
  - Functions rot_ccw(dir), rot_cw(dir).
- Sub-module robo_pose: pose registers, rotation, boundary-wall detection (outputs at_edge_ahead).
- Top robo_n holds the FSM and counters.

## Test plan
- Open 20×20, start (10,10,N), FOLLOW_RIGHT=0, head=side=0 → avancar every cycle; row 10→1. At row 1 the virtual wall gives girar×3 and dir N→O→S→L, ending in FOLLOW.
- FOLLOW with side=1, head=1 → exactly three girar cycles (dir L→N→O→S), then FOLLOW; turn_run=3.
- FOLLOW, side=0 → girar then STEP. Next cycle head=0 → avancar, FOLLOW, turn_run cleared.
- under=1 in FOLLOW → remover=1, pose unchanged, rem_count 0→1. head=1, barrier=1 → remover. Same at row 1 facing N with barrier=1 → no remover (virtual wall), girar instead.
- Enclosed cell (head=side=1 always), STUCK_TURNS=8 → 8 girar, halt=1 on the 8th, then all actions 0. MAX_MOVES=5 in open field → halt with the 5th avancar, move_count=5.
- Reset asserted during ROTATE with rot_left=1 → next cycle pose=START, state SEEK, all outputs at reset values. FOLLOW_RIGHT=1 rotation is N→L→S→O.

Source files
------------

// File: rtl/robo_pkg.sv
// Shared types and helpers for the wall-following robot controller:
// heading encoding, FSM state encoding and the two rotation functions.
package robo_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'b00,
        DIR_S = 2'b01,
        DIR_L = 2'b10,
        DIR_O = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_SEEK,
        ST_FOLLOW,
        ST_STEP,
        ST_ROTATE,
        ST_HALT
    } state_t;

    // Two more turns after the first one put the wall on the follow side.
    localparam logic [1:0] ROT_INIT = 2'd2;

    function automatic dir_t rot_ccw(input dir_t d);
        case (d)
            DIR_N:   rot_ccw = DIR_O;
            DIR_O:   rot_ccw = DIR_S;
            DIR_S:   rot_ccw = DIR_L;
            default: rot_ccw = DIR_N;
        endcase
    endfunction

    function automatic dir_t rot_cw(input dir_t d);
        case (d)
            DIR_N:   rot_cw = DIR_L;
            DIR_L:   rot_cw = DIR_S;
            DIR_S:   rot_cw = DIR_O;
            default: rot_cw = DIR_N;
        endcase
    endfunction

endpackage

// File: rtl/robo_pose.sv
// Pose tracker: row/col/heading registers updated on the same edge as the
// action, plus detection of the map boundary directly ahead.
module robo_pose
    import robo_pkg::*;
#(
    parameter int         GRID         = 20,
    parameter int         POS_W        = 5,
    parameter int         FOLLOW_RIGHT = 0,
    parameter int         START_ROW    = 1,
    parameter int         START_COL    = 1,
    parameter logic [1:0] START_DIR    = 2'b00
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             adv_i,
    input  logic             turn_i,
    output logic [POS_W-1:0] row_o,
    output logic [POS_W-1:0] col_o,
    output logic [1:0]       dir_o,
    output logic             at_edge_ahead_o
);

    logic [POS_W-1:0] row_q, row_d;
    logic [POS_W-1:0] col_q, col_d;
    dir_t             dir_q, dir_d;
    logic             at_edge;

    always_comb begin
        unique case (dir_q)
            DIR_N:   at_edge = (row_q == POS_W'(1));
            DIR_S:   at_edge = (row_q == POS_W'(GRID));
            DIR_L:   at_edge = (col_q == POS_W'(GRID));
            default: at_edge = (col_q == POS_W'(1));
        endcase
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        dir_d = dir_q;
        if (turn_i) begin
            dir_d = (FOLLOW_RIGHT != 0) ? rot_cw(dir_q) : rot_ccw(dir_q);
        end else if (adv_i && !at_edge) begin
            // The edge guard keeps the pose inside 1..GRID even if misdriven.
            unique case (dir_q)
                DIR_N:   row_d = row_q - POS_W'(1);
                DIR_S:   row_d = row_q + POS_W'(1);
                DIR_L:   col_d = col_q + POS_W'(1);
                default: col_d = col_q - POS_W'(1);
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_q <= POS_W'(START_ROW);
            col_q <= POS_W'(START_COL);
            dir_q <= dir_t'(START_DIR);
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            dir_q <= dir_d;
        end
    end

    assign row_o           = row_q;
    assign col_o           = col_q;
    assign dir_o           = dir_q;
    assign at_edge_ahead_o = at_edge;

endmodule

// File: rtl/robo_n.sv
// Wall-following robot controller: sensor-driven FSM issuing one registered
// action per cycle, with move/removal counters and sticky halt detection.
module robo_n
    import robo_pkg::*;
#(
    parameter int         GRID         = 20,
    parameter int         POS_W        = 5,
    parameter int         FOLLOW_RIGHT = 0,
    parameter int         START_ROW    = 1,
    parameter int         START_COL    = 1,
    parameter logic [1:0] START_DIR    = 2'b00,
    parameter int         MAX_MOVES    = 200,
    parameter int         STUCK_TURNS  = 8,
    parameter int         CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             head,
    input  logic             side,
    input  logic             under,
    input  logic             barrier,
    output logic             avancar,
    output logic             girar,
    output logic             remover,
    output logic             halt,
    output logic [POS_W-1:0] row,
    output logic [POS_W-1:0] col,
    output logic [1:0]       dir,
    output logic [CNT_W-1:0] move_count,
    output logic [CNT_W-1:0] rem_count
);

    localparam int TR_W = $clog2(STUCK_TURNS + 1);

    state_t           state_q, state_d;
    logic [1:0]       rot_q, rot_d;
    logic [TR_W-1:0]  turn_run_q, turn_run_d;
    logic [CNT_W-1:0] move_q, move_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             adv_q, gir_q, rmv_q, halt_q;
    logic             adv_d, gir_d, rmv_d, halt_set;
    logic             at_edge, head_eff, rmv_cond;

    // A virtual wall counts as an obstacle but can never be removed.
    assign head_eff = head | at_edge;
    assign rmv_cond = under | (head & barrier & ~at_edge);

    always_comb begin
        adv_d   = 1'b0;
        gir_d   = 1'b0;
        rmv_d   = 1'b0;
        state_d = state_q;
        rot_d   = rot_q;
        if (state_q == ST_SEEK || state_q == ST_FOLLOW || state_q == ST_STEP) begin
            if (rmv_cond) begin
                rmv_d = 1'b1;
            end else if (state_q == ST_FOLLOW && !side) begin
                gir_d   = 1'b1;
                state_d = ST_STEP;
            end else if (!head_eff) begin
                adv_d = 1'b1;
                if (state_q == ST_STEP) state_d = ST_FOLLOW;
            end else begin
                gir_d   = 1'b1;
                rot_d   = ROT_INIT;
                state_d = ST_ROTATE;
            end
        end else if (state_q == ST_ROTATE) begin
            gir_d = 1'b1;
            rot_d = rot_q - 2'd1;
            if (rot_q == 2'd1) state_d = ST_FOLLOW;
        end

        halt_set = (gir_d && turn_run_q == TR_W'(STUCK_TURNS - 1)) ||
                   (adv_d && move_q == CNT_W'(MAX_MOVES - 1));
        if (halt_set) state_d = ST_HALT;

        turn_run_d = turn_run_q;
        if (adv_d)      turn_run_d = '0;
        else if (gir_d) turn_run_d = turn_run_q + TR_W'(1);

        move_d = move_q + CNT_W'(adv_d);
        rem_d  = (rmv_d && rem_q != '1) ? rem_q + CNT_W'(1) : rem_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_SEEK;
            rot_q      <= '0;
            turn_run_q <= '0;
            move_q     <= '0;
            rem_q      <= '0;
            adv_q      <= 1'b0;
            gir_q      <= 1'b0;
            rmv_q      <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rot_q      <= rot_d;
            turn_run_q <= turn_run_d;
            move_q     <= move_d;
            rem_q      <= rem_d;
            adv_q      <= adv_d;
            gir_q      <= gir_d;
            rmv_q      <= rmv_d;
            halt_q     <= halt_q | halt_set;
        end
    end

    robo_pose #(
        .GRID         (GRID),
        .POS_W        (POS_W),
        .FOLLOW_RIGHT (FOLLOW_RIGHT),
        .START_ROW    (START_ROW),
        .START_COL    (START_COL),
        .START_DIR    (START_DIR)
    ) u_pose (
        .clock           (clock),
        .reset           (reset),
        .adv_i           (adv_d),
        .turn_i          (gir_d),
        .row_o           (row),
        .col_o           (col),
        .dir_o           (dir),
        .at_edge_ahead_o (at_edge)
    );

    assign avancar    = adv_q;
    assign girar      = gir_q;
    assign remover    = rmv_q;
    assign halt       = halt_q;
    assign move_count = move_q;
    assign rem_count  = rem_q;

endmodule

// File: tb/tb_robo_n.sv
// Scoreboard bench for robo_n: directed stimulus pushes hand-computed expected
// outputs into per-instance queues; monitors pop and compare after each edge.
module tb_robo_n;

    typedef struct packed {
        logic       av;
        logic       gi;
        logic       rm;
        logic       ht;
        logic [4:0] row;
        logic [4:0] col;
        logic [1:0] dir;
        logic [7:0] mc;
        logic [7:0] rc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: left-hand follow, start (10,10,N)
    logic       a_reset, a_head, a_side, a_under, a_barrier;
    logic       a_av, a_gi, a_rm, a_ht;
    logic [4:0] a_row, a_col;
    logic [1:0] a_dir;
    logic [7:0] a_mc, a_rc;

    // Instance B: right-hand follow, start (5,10,N), move budget 5
    logic       b_reset, b_head, b_side, b_under, b_barrier;
    logic       b_av, b_gi, b_rm, b_ht;
    logic [4:0] b_row, b_col;
    logic [1:0] b_dir;
    logic [7:0] b_mc, b_rc;

    robo_n #(
        .GRID(20), .POS_W(5), .FOLLOW_RIGHT(0), .START_ROW(10), .START_COL(10),
        .START_DIR(2'b00), .MAX_MOVES(200), .STUCK_TURNS(8), .CNT_W(8)
    ) dut_a (
        .clock(clk), .reset(a_reset), .head(a_head), .side(a_side),
        .under(a_under), .barrier(a_barrier), .avancar(a_av), .girar(a_gi),
        .remover(a_rm), .halt(a_ht), .row(a_row), .col(a_col), .dir(a_dir),
        .move_count(a_mc), .rem_count(a_rc)
    );

    robo_n #(
        .GRID(20), .POS_W(5), .FOLLOW_RIGHT(1), .START_ROW(5), .START_COL(10),
        .START_DIR(2'b00), .MAX_MOVES(5), .STUCK_TURNS(8), .CNT_W(8)
    ) dut_b (
        .clock(clk), .reset(b_reset), .head(b_head), .side(b_side),
        .under(b_under), .barrier(b_barrier), .avancar(b_av), .girar(b_gi),
        .remover(b_rm), .halt(b_ht), .row(b_row), .col(b_col), .dir(b_dir),
        .move_count(b_mc), .rem_count(b_rc)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    exp_t ea, eb;

    function automatic exp_t mk(input logic av, gi, rm, ht,
                                input int r, c, d, mc, rc);
        exp_t e;
        e.av  = av;
        e.gi  = gi;
        e.rm  = rm;
        e.ht  = ht;
        e.row = r[4:0];
        e.col = c[4:0];
        e.dir = d[1:0];
        e.mc  = mc[7:0];
        e.rc  = rc[7:0];
        return e;
    endfunction

    task automatic check(input string tag, input exp_t got, input exp_t req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s txn%0d: got av=%b gi=%b rm=%b ht=%b pose=(%0d,%0d,%0d) mc=%0d rc=%0d, required av=%b gi=%b rm=%b ht=%b pose=(%0d,%0d,%0d) mc=%0d rc=%0d",
                     tag, checks, got.av, got.gi, got.rm, got.ht, got.row, got.col, got.dir,
                     got.mc, got.rc, req.av, req.gi, req.rm, req.ht, req.row, req.col,
                     req.dir, req.mc, req.rc);
        end else begin
            $display("txn %s%0d ok: av=%b gi=%b rm=%b ht=%b pose=(%0d,%0d,%0d) mc=%0d rc=%0d",
                     tag, checks, got.av, got.gi, got.rm, got.ht, got.row, got.col, got.dir,
                     got.mc, got.rc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            check("A", {a_av, a_gi, a_rm, a_ht, a_row, a_col, a_dir, a_mc, a_rc}, ea);
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            check("B", {b_av, b_gi, b_rm, b_ht, b_row, b_col, b_dir, b_mc, b_rc}, eb);
        end
    end

    task automatic sa(input logic r, h, s, u, b, input exp_t e);
        @(negedge clk);
        a_reset = r; a_head = h; a_side = s; a_under = u; a_barrier = b;
        qa.push_back(e);
    endtask

    task automatic sb(input logic r, h, s, u, b, input exp_t e);
        @(negedge clk);
        b_reset = r; b_head = h; b_side = s; b_under = u; b_barrier = b;
        qb.push_back(e);
    endtask

    logic [1:0] ccw_seq [8];

    initial begin
        a_reset = 1'b1; a_head = 1'b0; a_side = 1'b0; a_under = 1'b0; a_barrier = 1'b0;
        b_reset = 1'b1; b_head = 1'b0; b_side = 1'b0; b_under = 1'b0; b_barrier = 1'b0;
        ccw_seq = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2};

        // Reset state
        sa(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 10, 10, 0, 0, 0));
        sa(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 10, 10, 0, 0, 0));
        // Open field north: row 10 -> 1
        for (int k = 1; k <= 9; k++)
            sa(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 10 - k, 10, 0, k, 0));
        // Virtual wall at row 1: three turns N->O->S->L
        sa(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 1, 10, 3, 9, 0));
        sa(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 1, 10, 1, 9, 0));
        sa(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 1, 10, 2, 9, 0));
        // FOLLOW, wall on side, clear ahead
        sa(0, 0, 1, 0, 0, mk(1, 0, 0, 0, 1, 11, 2, 10, 0));
        // FOLLOW, corner: L->N->O->S
        sa(0, 1, 1, 0, 0, mk(0, 1, 0, 0, 1, 11, 0, 10, 0));
        sa(0, 1, 1, 0, 0, mk(0, 1, 0, 0, 1, 11, 3, 10, 0));
        sa(0, 1, 1, 0, 0, mk(0, 1, 0, 0, 1, 11, 1, 10, 0));
        // Lost wall: turn into STEP, then advance back to FOLLOW
        sa(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 1, 11, 2, 10, 0));
        sa(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 1, 12, 2, 11, 0));
        // Removals: debris underneath, then removable obstacle ahead
        sa(0, 0, 1, 1, 0, mk(0, 0, 1, 0, 1, 12, 2, 11, 1));
        sa(0, 1, 1, 0, 1, mk(0, 0, 1, 0, 1, 12, 2, 11, 2));
        // Face N at row 1; barrier=1 against virtual wall must turn, not remove
        sa(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 1, 12, 0, 11, 2));
        sa(0, 1, 1, 0, 1, mk(0, 1, 0, 0, 1, 12, 3, 11, 2));
        sa(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 1, 12, 1, 11, 2));
        sa(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 1, 12, 2, 11, 2));
        // Clear turn_run with one advance, then enclosed: halt on 8th turn
        sa(0, 0, 1, 0, 0, mk(1, 0, 0, 0, 1, 13, 2, 12, 2));
        for (int i = 0; i < 8; i++)
            sa(0, 1, 1, 0, 0, mk(0, 1, 0, i == 7, 1, 13, ccw_seq[i], 12, 2));
        sa(0, 0, 0, 1, 0, mk(0, 0, 0, 1, 1, 13, 2, 12, 2));
        sa(0, 0, 0, 0, 0, mk(0, 0, 0, 1, 1, 13, 2, 12, 2));
        // Reset from HALT, then reset mid-ROTATE with rot_left=1
        sa(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 10, 10, 0, 0, 0));
        sa(0, 1, 0, 0, 0, mk(0, 1, 0, 0, 10, 10, 3, 0, 0));
        sa(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 10, 10, 1, 0, 0));
        sa(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 10, 10, 0, 0, 0));
        sa(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 9, 10, 0, 1, 0));
        @(negedge clk);
        a_reset = 1'b1;

        // Instance B: CW rotation N->L->S->O, then move budget of 5
        sb(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 5, 10, 0, 0, 0));
        sb(0, 1, 0, 0, 0, mk(0, 1, 0, 0, 5, 10, 2, 0, 0));
        sb(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 5, 10, 1, 0, 0));
        sb(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 5, 10, 3, 0, 0));
        for (int k = 1; k <= 5; k++)
            sb(0, 0, 1, 0, 0, mk(1, 0, 0, k == 5, 5, 10 - k, 3, k, 0));
        sb(0, 0, 1, 1, 0, mk(0, 0, 0, 1, 5, 5, 3, 5, 0));
        sb(0, 0, 1, 0, 0, mk(0, 0, 0, 1, 5, 5, 3, 5, 0));

        repeat (3) @(negedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d required=0", qa.size() + qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
